// File: rtl/msj_platform_ctrl_nch.sv
// N-channel MSJ platform controller: PWM per actuator, round-robin SPI angle polling,
// soft limits, latched emergency stop. Optional macro ANGLE_PARITY_CHECK_EN adds frame parity checking.
//
// state      | meaning
// S_IDLE     | sequencer parked, waiting for spi_enable
// S_SELECT   | ss_n[ch] low, one half-period before the first SCK edge
// S_SHIFT    | 16 SCK cycles, drive on rise, sample miso on fall
// S_DESELECT | ss_n high for CS_GAP clocks, frame committed at the end
// S_NEXT     | advance channel, resume or park
module msj_platform_ctrl_nch #(
  parameter int NUM_CH      = 8,
  parameter int PWM_WIDTH   = 16,
  parameter int PWM_PERIOD  = 1000,
  parameter int SPI_CLK_DIV = 25,
  parameter int CS_GAP      = 50
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [7:0]        address,
  input  logic              write,
  input  logic [31:0]       writedata,
  input  logic              read,
  output logic [31:0]       readdata,
  output logic [NUM_CH-1:0] pwm,
  input  logic              angle_miso,
  output logic              angle_mosi,
  output logic              angle_sck,
  output logic [NUM_CH-1:0] angle_ss_n_o,
  input  logic              emergency_off
);

  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam logic [PWM_WIDTH-1:0] CNT_MAX  = PWM_WIDTH'(PWM_PERIOD - 1);
  localparam logic [15:0]          DIV_LOAD = 16'(SPI_CLK_DIV - 1);
  localparam logic [15:0]          GAP_LOAD = 16'(CS_GAP - 1);
  localparam logic [CH_W-1:0]      CH_MAX   = CH_W'(NUM_CH - 1);

  typedef enum logic [2:0] {S_IDLE, S_SELECT, S_SHIFT, S_DESELECT, S_NEXT} spi_state_t;

  logic [PWM_WIDTH-1:0] duty_q   [NUM_CH];
  logic [PWM_WIDTH-1:0] active_q [NUM_CH];
  logic [13:0]          angle_q  [NUM_CH];
  logic [13:0]          min_q    [NUM_CH];
  logic [13:0]          max_q    [NUM_CH];
  logic [1:0]           ctrl_q;
  logic                 estop_q;
  logic [NUM_CH-1:0]    viol_q;
  logic [NUM_CH-1:0]    viol_now;
  logic [PWM_WIDTH-1:0] cnt_q;
  logic [NUM_CH-1:0]    pwm_q;
  logic                 es_s1_q, es_s2_q;
  logic                 kill;
  logic [31:0]          rdata_q, rdata_d;

  spi_state_t        state_q, state_d;
  logic [15:0]       tmr_q, tmr_d;
  logic [3:0]        bit_q, bit_d;
  logic [15:0]       shift_q, shift_d;
  logic [CH_W-1:0]   ch_q, ch_d;
  logic              sck_q, sck_d;
  logic              mosi_q, mosi_d;
  logic [NUM_CH-1:0] ss_n_q, ss_n_d;
  logic              commit;
  logic              frame_ok;

  wire wr_ctrl   = write && (address == 8'h40);
  wire wr_status = write && (address == 8'h41);

`ifdef ANGLE_PARITY_CHECK_EN
  logic [15:0] err_q;
  wire parity_ok = ~(^shift_q);
  assign frame_ok = parity_ok && !shift_q[14];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      err_q <= '0;
    end else if (write && (address == 8'h42)) begin
      err_q <= '0;
    end else if (commit && !parity_ok && (err_q != 16'hFFFF)) begin
      err_q <= err_q + 16'd1;
    end
  end
`else
  assign frame_ok = !shift_q[14];
`endif

  assign kill = estop_q | es_s2_q;

  always_comb begin
    viol_now = '0;
    for (int ch = 0; ch < NUM_CH; ch++) begin
      viol_now[ch] = ctrl_q[1] && ((angle_q[ch] < min_q[ch]) || (angle_q[ch] > max_q[ch]));
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      es_s1_q <= 1'b0;
      es_s2_q <= 1'b0;
    end else begin
      es_s1_q <= emergency_off;
      es_s2_q <= es_s1_q;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int ch = 0; ch < NUM_CH; ch++) begin
        duty_q[ch]  <= '0;
        angle_q[ch] <= '0;
        min_q[ch]   <= '0;
        max_q[ch]   <= 14'h3FFF;
      end
      ctrl_q  <= '0;
      estop_q <= 1'b0;
      viol_q  <= '0;
    end else begin
      for (int ch = 0; ch < NUM_CH; ch++) begin
        if (write && (address == 8'(ch)))      duty_q[ch] <= writedata[PWM_WIDTH-1:0];
        if (write && (address == 8'(32 + ch))) min_q[ch]  <= writedata[13:0];
        if (write && (address == 8'(48 + ch))) max_q[ch]  <= writedata[13:0];
        if (commit && frame_ok && (ch_q == CH_W'(ch))) angle_q[ch] <= shift_q[13:0];
        if (viol_now[ch])                         viol_q[ch] <= 1'b1;
        else if (wr_status && writedata[16 + ch]) viol_q[ch] <= 1'b0;
      end
      if (wr_ctrl) ctrl_q <= writedata[1:0];
      // A clear only wins once the synchronised stop input has dropped.
      if (es_s2_q)                        estop_q <= 1'b1;
      else if (wr_status && writedata[0]) estop_q <= 1'b0;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
      pwm_q <= '0;
      for (int ch = 0; ch < NUM_CH; ch++) active_q[ch] <= '0;
    end else begin
      cnt_q <= (cnt_q == CNT_MAX) ? '0 : cnt_q + 1'b1;
      for (int ch = 0; ch < NUM_CH; ch++) begin
        if (cnt_q == CNT_MAX) active_q[ch] <= duty_q[ch];
        pwm_q[ch] <= (cnt_q < active_q[ch]) && !kill && !viol_now[ch];
      end
    end
  end

  always_comb begin
    rdata_d = '0;
    for (int ch = 0; ch < NUM_CH; ch++) begin
      if (address == 8'(ch))      rdata_d = 32'(duty_q[ch]);
      if (address == 8'(16 + ch)) rdata_d = {18'b0, angle_q[ch]};
      if (address == 8'(32 + ch)) rdata_d = {18'b0, min_q[ch]};
      if (address == 8'(48 + ch)) rdata_d = {18'b0, max_q[ch]};
    end
    if (address == 8'h40) rdata_d = {30'b0, ctrl_q};
    if (address == 8'h41) rdata_d = {16'(viol_q), 15'b0, estop_q};
`ifdef ANGLE_PARITY_CHECK_EN
    if (address == 8'h42) rdata_d = {16'b0, err_q};
`endif
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset)     rdata_q <= '0;
    else if (read) rdata_q <= rdata_d;
  end

  always_comb begin
    state_d = state_q;
    tmr_d   = tmr_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    ch_d    = ch_q;
    sck_d   = sck_q;
    commit  = 1'b0;
    case (state_q)
      S_IDLE: begin
        sck_d = 1'b0;
        if (ctrl_q[0]) begin
          state_d = S_SELECT;
          tmr_d   = DIV_LOAD;
        end
      end
      S_SELECT: begin
        if (tmr_q == '0) begin
          state_d = S_SHIFT;
          tmr_d   = DIV_LOAD;
          bit_d   = '0;
        end else begin
          tmr_d = tmr_q - 16'd1;
        end
      end
      S_SHIFT: begin
        if (tmr_q == '0) begin
          tmr_d = DIV_LOAD;
          if (!sck_q) begin
            sck_d = 1'b1;
          end else begin
            sck_d   = 1'b0;
            shift_d = {shift_q[14:0], angle_miso};
            if (bit_q == 4'd15) begin
              state_d = S_DESELECT;
              tmr_d   = GAP_LOAD;
            end else begin
              bit_d = bit_q + 4'd1;
            end
          end
        end else begin
          tmr_d = tmr_q - 16'd1;
        end
      end
      S_DESELECT: begin
        if (tmr_q == '0) begin
          commit  = 1'b1;
          state_d = S_NEXT;
        end else begin
          tmr_d = tmr_q - 16'd1;
        end
      end
      S_NEXT: begin
        ch_d    = (ch_q == CH_MAX) ? '0 : ch_q + 1'b1;
        tmr_d   = DIV_LOAD;
        state_d = ctrl_q[0] ? S_SELECT : S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Select and MOSI follow the next state so they stay aligned with it.
    ss_n_d = '1;
    mosi_d = 1'b0;
    if ((state_d == S_SELECT) || (state_d == S_SHIFT)) begin
      mosi_d = 1'b1;
      for (int ch = 0; ch < NUM_CH; ch++) ss_n_d[ch] = (ch_d != CH_W'(ch));
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      tmr_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      ch_q    <= '0;
      sck_q   <= 1'b0;
      mosi_q  <= 1'b0;
      ss_n_q  <= '1;
    end else begin
      state_q <= state_d;
      tmr_q   <= tmr_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      ch_q    <= ch_d;
      sck_q   <= sck_d;
      mosi_q  <= mosi_d;
      ss_n_q  <= ss_n_d;
    end
  end

  assign readdata     = rdata_q;
  assign pwm          = pwm_q;
  assign angle_sck    = sck_q;
  assign angle_mosi   = mosi_q;
  assign angle_ss_n_o = ss_n_q;

endmodule

// File: tb/tb_msj_platform_ctrl_nch.sv
// Self-checking bench for msj_platform_ctrl_nch: register table, PWM duty windows,
// SPI sensor model, soft limits, emergency stop and (optionally) parity errors.
module tb_msj_platform_ctrl_nch;
  localparam int NUM_CH      = 4;
  localparam int PWM_PERIOD  = 1000;
  localparam int SPI_CLK_DIV = 4;
  localparam int CS_GAP      = 8;

  logic              clock = 1'b0;
  logic              reset = 1'b1;
  logic [7:0]        address = '0;
  logic              write = 1'b0;
  logic [31:0]       writedata = '0;
  logic              read = 1'b0;
  logic [31:0]       readdata;
  logic [NUM_CH-1:0] pwm;
  logic              angle_miso = 1'b0;
  logic              angle_mosi;
  logic              angle_sck;
  logic [NUM_CH-1:0] angle_ss_n_o;
  logic              emergency_off = 1'b0;

  msj_platform_ctrl_nch #(
    .NUM_CH(NUM_CH), .PWM_WIDTH(16), .PWM_PERIOD(PWM_PERIOD),
    .SPI_CLK_DIV(SPI_CLK_DIV), .CS_GAP(CS_GAP)
  ) dut (
    .clock(clock), .reset(reset), .address(address), .write(write),
    .writedata(writedata), .read(read), .readdata(readdata), .pwm(pwm),
    .angle_miso(angle_miso), .angle_mosi(angle_mosi), .angle_sck(angle_sck),
    .angle_ss_n_o(angle_ss_n_o), .emergency_off(emergency_off)
  );

  always #5 clock = ~clock;

  int n_pass  = 0;
  int n_total = 0;

  typedef struct { logic [31:0] exp; string name; } sb_t;
  sb_t sb_q[$];

  typedef struct {
    logic [7:0]  addr;
    logic        do_wr;
    logic [31:0] wdata;
    logic [31:0] exp;
    string       name;
  } vec_t;
  vec_t vt[$];

  // Sensor model: mode 1 slave, next bit driven on each SCK rise, 16 rises per frame.
  logic [15:0] sensor  [NUM_CH];
  logic        bad_par [NUM_CH];
  int          rise_cnt = 0;
  int          sel_ch;
  logic [15:0] frame_v;

  function automatic logic [15:0] mkframe(input logic [15:0] v, input logic bad);
    mkframe = {(^v[14:0]) ^ bad, v[14:0]};
  endfunction

  always @(posedge angle_sck) begin
    sel_ch = 0;
    for (int i = 0; i < NUM_CH; i++) if (!angle_ss_n_o[i]) sel_ch = i;
    frame_v    = mkframe(sensor[sel_ch], bad_par[sel_ch]);
    angle_miso = frame_v[15 - rise_cnt];
    rise_cnt   = (rise_cnt + 1) % 16;
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic wr(input logic [7:0] a, input logic [31:0] d);
    address   = a;
    writedata = d;
    write     = 1'b1;
    tick();
    write     = 1'b0;
  endtask

  task automatic rd_exp(input logic [7:0] a, input logic [31:0] exp, input string name);
    sb_t item;
    sb_q.push_back('{exp: exp, name: name});
    address = a;
    read    = 1'b1;
    tick();
    read    = 1'b0;
    item = sb_q.pop_front();
    check(item.name, readdata, item.exp);
  endtask

  // mode 0: wait ss_n[ch]==lvl; mode 1: all deselected; mode 2: any selected
  task automatic wait_ss(input int mode, input int ch, input logic lvl, input int budget, input string name);
    int n = 0;
    logic ok;
    ok = 1'b0;
    while (n < budget) begin
      if (mode == 0) ok = (angle_ss_n_o[ch] === lvl);
      else if (mode == 1) ok = (&angle_ss_n_o) === 1'b1;
      else ok = (&angle_ss_n_o) === 1'b0;
      if (ok) break;
      tick();
      n++;
    end
    check(name, {31'b0, ok}, 32'd1);
  endtask

  task automatic wait_pwm(input int ch, input logic lvl, input int budget, input string name);
    int n = 0;
    while ((pwm[ch] !== lvl) && (n < budget)) begin
      tick();
      n++;
    end
    check(name, {31'b0, pwm[ch]}, {31'b0, lvl});
  endtask

  task automatic count_high(input int ch, input int n, output int c);
    c = 0;
    for (int k = 0; k < n; k++) begin
      tick();
      if (pwm[ch] === 1'b1) c++;
    end
  endtask

  task automatic add_vec(input logic [7:0] a, input logic w, input logic [31:0] d,
                         input logic [31:0] e, input string name);
    vt.push_back('{addr: a, do_wr: w, wdata: d, exp: e, name: name});
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int c, c1;
    for (int i = 0; i < NUM_CH; i++) begin
      sensor[i]  = 16'h0000;
      bad_par[i] = 1'b0;
    end
    sensor[0] = 16'h1234;
    sensor[1] = 16'h6ABC;
    sensor[2] = 16'h0555;
    sensor[3] = 16'h0777;

    repeat (3) tick();
    reset = 1'b0;
    tick();
    check("rst_ss_n", 32'(angle_ss_n_o), 32'hF);
    check("rst_pwm", 32'(pwm), 32'h0);
    check("rst_sck", {31'b0, angle_sck}, 32'h0);
    check("rst_mosi", {31'b0, angle_mosi}, 32'h0);
    check("rst_readdata", readdata, 32'h0);

    add_vec(8'h40, 1'b0, 32'h0,        32'h0,    "ctrl_reset");
    add_vec(8'h41, 1'b0, 32'h0,        32'h0,    "status_reset");
    add_vec(8'h30, 1'b0, 32'h0,        32'h3FFF, "max0_reset");
    add_vec(8'h33, 1'b0, 32'h0,        32'h3FFF, "max3_reset");
    add_vec(8'h20, 1'b0, 32'h0,        32'h0,    "min0_reset");
    add_vec(8'h01, 1'b1, 32'h0000ABCD, 32'hABCD, "duty1_rw");
    add_vec(8'h21, 1'b1, 32'hFFFFC123, 32'h0123, "min1_14bit");
    add_vec(8'h10, 1'b1, 32'h00000055, 32'h0,    "angle0_ro");
    add_vec(8'h50, 1'b1, 32'h00000077, 32'h0,    "unmapped_50");
    add_vec(8'h24, 1'b1, 32'h00000099, 32'h0,    "unmapped_ch4");
    add_vec(8'h42, 1'b0, 32'h0,        32'h0,    "errcnt_reset");
    add_vec(8'h21, 1'b1, 32'h0,        32'h0,    "min1_restore");
    add_vec(8'h01, 1'b1, 32'h0,        32'h0,    "duty1_restore");
    for (int i = 0; i < vt.size(); i++) begin
      if (vt[i].do_wr) wr(vt[i].addr, vt[i].wdata);
      rd_exp(vt[i].addr, vt[i].exp, vt[i].name);
    end

    // PWM duty 250 of 1000, then constant high, then constant low
    wr(8'h02, 32'd250);
    wait_pwm(2, 1'b1, 2 * PWM_PERIOD, "pwm2_rise");
    count_high(2, PWM_PERIOD, c);
    check("pwm2_duty250_p1", 32'(c), 32'd250);
    count_high(2, PWM_PERIOD, c);
    check("pwm2_duty250_p2", 32'(c), 32'd250);
    wr(8'h02, 32'd1000);
    repeat (PWM_PERIOD + 100) tick();
    count_high(2, PWM_PERIOD, c);
    check("pwm2_duty_full", 32'(c), 32'd1000);
    wr(8'h02, 32'd0);
    repeat (PWM_PERIOD + 100) tick();
    count_high(2, PWM_PERIOD, c);
    check("pwm2_duty_zero", 32'(c), 32'd0);

    // SPI round robin
    wr(8'h40, 32'h1);
    wait_ss(0, 3, 1'b0, 1000, "spi_reach_ch3");
    rd_exp(8'h10, 32'h1234, "angle0_commit");
    rd_exp(8'h11, 32'h0,    "angle1_errflag_kept");
    rd_exp(8'h12, 32'h0555, "angle2_commit");
    sensor[0] = 16'h0300;
    wait_ss(1, 0, 1'b1, 300, "spi_ch3_end");
    wait_ss(2, 0, 1'b0, 50, "spi_next_select");
    check("spi_wrap_to_ch0", 32'(angle_ss_n_o), 32'hE);
    check("spi_mosi_high", {31'b0, angle_mosi}, 32'h1);
    rd_exp(8'h13, 32'h0777, "angle3_commit");
    wr(8'h40, 32'h0);
    wait_ss(1, 0, 1'b1, 300, "spi_disable_end");
    check("spi_full_frame", 32'(rise_cnt), 32'd0);
    repeat (30) tick();
    rd_exp(8'h10, 32'h0300, "angle0_after_disable");
    repeat (200) tick();
    check("spi_idle_ss_n", 32'(angle_ss_n_o), 32'hF);
    check("spi_idle_sck", {31'b0, angle_sck}, 32'h0);

    // Soft limits on ch0 only
    wr(8'h00, 32'd500);
    wr(8'h01, 32'd500);
    wr(8'h20, 32'h100);
    wr(8'h30, 32'h200);
    wr(8'h40, 32'h2);
    repeat (PWM_PERIOD + 100) tick();
    c = 0;
    c1 = 0;
    for (int k = 0; k < PWM_PERIOD; k++) begin
      tick();
      if (pwm[0] === 1'b1) c++;
      if (pwm[1] === 1'b1) c1++;
    end
    check("limit_pwm0_forced", 32'(c), 32'd0);
    check("limit_pwm1_free", 32'(c1), 32'd500);
    rd_exp(8'h41, 32'h0001_0000, "limit_status");

    // Emergency stop
    wr(8'h40, 32'h0);
    wr(8'h41, 32'h0001_0000);
    rd_exp(8'h41, 32'h0, "limit_w1c");
    wait_pwm(0, 1'b0, 2 * PWM_PERIOD, "estop_pre_low");
    wait_pwm(0, 1'b1, 2 * PWM_PERIOD, "estop_pre_high");
    emergency_off = 1'b1;
    repeat (3) tick();
    check("estop_within_3clk", 32'(pwm), 32'h0);
    wr(8'h41, 32'h1);
    tick();
    emergency_off = 1'b0;
    repeat (5) tick();
    rd_exp(8'h41, 32'h1, "estop_w1c_ignored");
    count_high(0, PWM_PERIOD, c);
    check("estop_latched_pwm0", 32'(c), 32'd0);
    wr(8'h41, 32'h1);
    rd_exp(8'h41, 32'h0, "estop_cleared");
    count_high(0, PWM_PERIOD, c);
    check("estop_pwm0_restored", 32'(c), 32'd500);

    // Bad parity frames on ch1
    sensor[1]  = 16'h0111;
    bad_par[1] = 1'b1;
    wr(8'h40, 32'h1);
    for (int f = 0; f < 3; f++) begin
      wait_ss(0, 1, 1'b0, 800, "par_ch1_select");
      wait_ss(0, 1, 1'b1, 300, "par_ch1_end");
    end
    wr(8'h40, 32'h0);
    repeat (40) tick();
`ifdef ANGLE_PARITY_CHECK_EN
    rd_exp(8'h11, 32'h0, "par_angle1_kept");
    rd_exp(8'h42, 32'd3, "par_errcnt_3");
    wr(8'h42, 32'h0);
    rd_exp(8'h42, 32'd0, "par_errcnt_clear");
`else
    rd_exp(8'h11, 32'h0111, "par_ignored_commit");
    rd_exp(8'h42, 32'd0,    "par_errcnt_absent");
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
